mac_unit: RTL and testbench
===========================

// Module: mac_unit
// PURPOSE
//  Signed multiply-accumulate element for the matrix accelerator datapath.
//  On every enabled cycle it adds a*b to a running accumulator.
//  It is the compute leaf instantiated per processing element of the
//  matrix engine. Its accumulator is read directly by the result/AXI layer.
// PARAMETERS
//  DATA_W    8    width of signed operands a, b
//  ACC_W     32   width of signed accumulator; must be >= 2*DATA_W
//  SATURATE  0    0: two's-complement wrap on overflow; 1: clamp to min/max
// PORTS
//  clk    in   1       single clock; all state updates on rising edge
//  rst_n  in   1       reset, synchronous and ACTIVE-HIGH (1 = reset); name per codebase
//  en     in   1       accumulate enable: acc <= acc + a*b this edge
//  clr    in   1       synchronous clear of accumulator (no reset of flags beyond acc/ovf)
//  a      in   DATA_W  signed operand A
//  b      in   DATA_W  signed operand B
//  acc    out  ACC_W   signed accumulator, registered
//  ovf    out  1       sticky overflow flag, registered
// BEHAVIOUR
//  - Reset (rst_n=1 at posedge): acc <= 0, ovf <= 0. Reset wins over clr and en.
//  - Priority per edge: reset > clr > en > hold.
//  - clr=1: acc <= 0, ovf <= 0; a/b ignored that cycle.
//  - clr=1 with en=1 in the same cycle: clear only; no accumulate.
//  - en=1: product p = signed(a)*signed(b), full 2*DATA_W bits, sign-extended
//    to ACC_W+1; sum = acc + p computed at ACC_W+1 bits.
//  - en=0: acc and ovf hold.
//  - Latency: one cycle. With en high on edge N, acc shows the new value after edge N.
//    Back-to-back en cycles accumulate every cycle; no bubbles and no stall.
//  - Overflow: sum outside the signed ACC_W range sets ovf=1 (sticky until clr/reset).
//    SATURATE=0: acc <= sum[ACC_W-1:0] (wrap).
//    SATURATE=1: acc <= +max or -min per sign of sum.
//  - Operand extremes: -2^(DATA_W-1) * -2^(DATA_W-1) = +2^(2*DATA_W-2). It must be
//    represented exactly, so there is no product overflow.
//  - X/unknown on a/b while en=0 must not affect acc.
//  - No combinational path from inputs to outputs.
// STRUCTURE
//  - Shared package mac_pkg:
//    DATA_W and ACC_W default constants;
//    typedefs operand_t (logic signed [DATA_W-1:0]) and acc_t (logic signed [ACC_W-1:0]);
//    functions sat_add() returning {ovf, result}.
//  - One sub-module: mac_mult, a purely combinational signed DATA_W x DATA_W ->
//    2*DATA_W multiplier. It is isolated so it can later be pipelined or
//    replaced by a DSP primitive.
//  - Top holds the accumulator register, overflow detect, saturation mux and control priority.
// TESTING
//  1. Reset rst_n=1 for 2 cycles with en=1, a=3, b=4 -> acc=0, ovf=0 throughout.
//  2. en=1 one cycle with a=3, b=4 -> acc=12. Then en=1 with a=5, b=-2 -> acc=2.
//     Then en=0 for 3 cycles -> acc holds 2.
//  3. en=1 for 4 cycles with a=-128, b=-128 -> acc=16384, 32768, 49152, 65536; ovf=0.
//  4. acc=5, then clr=1 and en=1 same cycle with a=7, b=7 -> acc=0.
//     Next cycle en=1, a=2, b=3 -> acc=6.
//  5. ACC_W=16, SATURATE=0: accumulate 127*127 three times -> 16129, then 32258,
//     then wrap to -17149 with ovf=1. ovf stays 1 until clr.
//     Same stimulus with SATURATE=1 -> 32767, ovf=1.
//  6. Assert reset mid-accumulation (acc=100, en=1) -> acc=0 next edge.
//     Accumulation resumes cleanly after deassert.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath.
// Default operand/accumulator widths, their typedefs, and sat_add(). sat_add()
// works on a fixed wide container so that any accumulator width up to
// MAX_ACC_W can use it. It returns {ovf, result}.
package mac_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned MAX_ACC_W = 64;
  localparam int unsigned IDX_W     = $clog2(MAX_ACC_W + 1);

  typedef logic signed [DATA_W-1:0] operand_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // acc_x and p_x are sign-extended to MAX_ACC_W+1 bits. The operands fit in
  // acc_w bits, so their sum fits in acc_w+1 bits and bit acc_w is its true
  // sign. Overflow means bit acc_w differs from bit acc_w-1.
  function automatic logic [MAX_ACC_W:0] sat_add(input logic [MAX_ACC_W:0] acc_x,
                                                 input logic [MAX_ACC_W:0] p_x,
                                                 input int unsigned       acc_w,
                                                 input bit                saturate);
    logic [MAX_ACC_W:0] sum;
    logic [MAX_ACC_W:0] lim;
    logic [IDX_W-1:0]   msb;
    logic [IDX_W-1:0]   msb_m1;
    logic               hit;
    sum    = acc_x + p_x;
    msb    = IDX_W'(acc_w);
    msb_m1 = msb - IDX_W'(1);
    hit    = sum[msb] ^ sum[msb_m1];
    // The low acc_w bits of lim form the most negative value.
    // The low acc_w bits of lim-1 form the most positive value.
    lim         = '0;
    lim[msb_m1] = 1'b1;
    if (hit && saturate) begin
      sum = sum[msb] ? lim : lim - (MAX_ACC_W + 1)'(1);
    end
    return {hit, sum[MAX_ACC_W-1:0]};
  endfunction

endpackage

// File: rtl/mac_mult.sv
// Combinational signed DATA_W x DATA_W -> 2*DATA_W multiplier.
// It is kept separate so that it can be pipelined later or mapped to a DSP block.
// Ports:
//   a, b : signed operands
//   p    : full-width signed product (never overflows)
module mac_mult #(
  parameter int unsigned DATA_W = 8
) (
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] p
);

  logic [2*DATA_W-1:0] a_x;
  logic [2*DATA_W-1:0] b_x;

  // Sign-extend both operands to the product width. The low 2*DATA_W bits of
  // the two's-complement product are then exact.
  assign a_x = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_x = {{DATA_W{b[DATA_W-1]}}, b};
  assign p   = $signed(a_x * b_x);

endmodule

// File: rtl/mac_unit.sv
// Signed multiply-accumulate leaf for the matrix engine processing elements.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous reset, ACTIVE-HIGH (name kept from existing codebase)
//   en    : accumulate a*b this edge
//   clr   : synchronous clear of acc and ovf (beats en)
//   a, b  : signed operands
//   acc   : registered signed accumulator
//   ovf   : registered sticky overflow flag
// SATURATE=0 wraps on overflow. SATURATE=1 clamps to the signed min/max.
import mac_pkg::*;

module mac_unit #(
  parameter int unsigned DATA_W   = mac_pkg::DATA_W,
  parameter int unsigned ACC_W    = mac_pkg::ACC_W,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     ovf
);

  if (ACC_W < 2 * DATA_W || ACC_W > MAX_ACC_W) begin : g_bad_cfg
    $error("mac_unit: ACC_W must be within [2*DATA_W, MAX_ACC_W]");
  end

  logic signed [2*DATA_W-1:0] prod;
  logic [MAX_ACC_W:0]         acc_x;
  logic [MAX_ACC_W:0]         p_x;
  logic signed [ACC_W-1:0]    acc_d, acc_q;
  logic                       ovf_d, ovf_q;

  mac_mult #(
    .DATA_W(DATA_W)
  ) u_mult (
    .a(a),
    .b(b),
    .p(prod)
  );

  assign acc_x = {{(MAX_ACC_W + 1 - ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign p_x   = {{(MAX_ACC_W + 1 - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};

  // Priority: clr > en > hold. Reset is handled in the register below.
  // When en is low, the product is not selected, so X values on a/b cannot reach acc.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      acc_d = ACC_W'(sat_add(acc_x, p_x, ACC_W, SATURATE));
      ovf_d = ovf_q | 1'(sat_add(acc_x, p_x, ACC_W, SATURATE) >> MAX_ACC_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_mac_unit.sv
// Directed bench for mac_unit. Three instances share one stimulus:
// the default 8/32 wrap unit, a 16-bit wrap unit and a 16-bit saturating unit.
module tb_mac_unit;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              clr;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic signed [31:0] acc32;
  logic signed [15:0] accw;
  logic signed [15:0] accs;
  logic              ovf32, ovfw, ovfs;

  int n_assert = 0;
  int n_fail   = 0;

  mac_unit u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .acc(acc32), .ovf(ovf32)
  );

  mac_unit #(.DATA_W(8), .ACC_W(16), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .acc(accw), .ovf(ovfw)
  );

  mac_unit #(.DATA_W(8), .ACC_W(16), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .acc(accs), .ovf(ovfs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic c,
                       input logic signed [7:0] av, input logic signed [7:0] bv);
    rst_n = r; en = e; clr = c; a = av; b = bv;
  endtask

  initial begin
    // 1. reset with en active
    drive(1'b1, 1'b1, 1'b0, 8'sd3, 8'sd4);
    tick(); chk("rst_acc_c1", acc32, 0); chk("rst_ovf_c1", {31'd0, ovf32}, 0);
    tick(); chk("rst_acc_c2", acc32, 0); chk("rst_ovf_c2", {31'd0, ovf32}, 0);

    // 2. basic accumulate and hold (operands X while idle)
    drive(1'b0, 1'b1, 1'b0, 8'sd3, 8'sd4);   tick(); chk("acc_3x4", acc32, 12);
    drive(1'b0, 1'b1, 1'b0, 8'sd5, -8'sd2);  tick(); chk("acc_5xm2", acc32, 2);
    drive(1'b0, 1'b0, 1'b0, 'x, 'x);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("hold_x", acc32, 2);
    end

    // 3. operand extremes, back-to-back
    drive(1'b0, 1'b0, 1'b1, 8'sd0, 8'sd0);   tick(); chk("clr_a", acc32, 0);
    drive(1'b0, 1'b1, 1'b0, -8'sd128, -8'sd128);
    tick(); chk("ext_1", acc32, 16384);
    tick(); chk("ext_2", acc32, 32768);
    tick(); chk("ext_3", acc32, 49152);
    tick(); chk("ext_4", acc32, 65536);
    chk("ext_ovf", {31'd0, ovf32}, 0);

    // 4. clr beats en
    drive(1'b0, 1'b0, 1'b1, 8'sd0, 8'sd0);   tick();
    drive(1'b0, 1'b1, 1'b0, 8'sd5, 8'sd1);   tick(); chk("pre_clr", acc32, 5);
    drive(1'b0, 1'b1, 1'b1, 8'sd7, 8'sd7);   tick(); chk("clr_en", acc32, 0);
    drive(1'b0, 1'b1, 1'b0, 8'sd2, 8'sd3);   tick(); chk("post_clr", acc32, 6);

    // 5. 16-bit positive overflow, wrap vs saturate
    drive(1'b0, 1'b0, 1'b1, 8'sd0, 8'sd0);   tick();
    drive(1'b0, 1'b1, 1'b0, 8'sd127, 8'sd127);
    tick(); chk("w_1", accw, 16129); chk("s_1", accs, 16129);
    tick(); chk("w_2", accw, 32258); chk("s_2", accs, 32258);
    chk("w_ovf_2", {31'd0, ovfw}, 0);
    tick(); chk("w_3", accw, -17149); chk("s_3", accs, 32767); chk("m_3", acc32, 48387);
    chk("w_ovf_3", {31'd0, ovfw}, 1); chk("s_ovf_3", {31'd0, ovfs}, 1);
    chk("m_ovf_3", {31'd0, ovf32}, 0);
    drive(1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0);   tick();
    chk("w_ovf_hold", {31'd0, ovfw}, 1); chk("s_hold", accs, 32767);
    // Back in range: ovf must remain set
    drive(1'b0, 1'b1, 1'b0, 8'sd127, 8'sd127); tick();
    chk("w_4", accw, -1020); chk("w_ovf_sticky", {31'd0, ovfw}, 1);
    chk("s_4", accs, 32767);
    drive(1'b0, 1'b0, 1'b1, 8'sd0, 8'sd0);   tick();
    chk("w_ovf_clr", {31'd0, ovfw}, 0); chk("s_ovf_clr", {31'd0, ovfs}, 0);

    // 16-bit negative overflow
    drive(1'b0, 1'b1, 1'b0, -8'sd128, 8'sd127);
    tick(); chk("wn_1", accw, -16256);
    tick(); chk("wn_2", accw, -32512); chk("sn_2", accs, -32512);
    tick(); chk("wn_3", accw, 16768); chk("sn_3", accs, -32768);
    chk("sn_ovf", {31'd0, ovfs}, 1);

    // 6. reset during accumulation
    drive(1'b0, 1'b0, 1'b1, 8'sd0, 8'sd0);   tick();
    drive(1'b0, 1'b1, 1'b0, 8'sd10, 8'sd10); tick(); chk("pre_rst", acc32, 100);
    drive(1'b1, 1'b1, 1'b1, 8'sd10, 8'sd10); tick(); chk("mid_rst", acc32, 0);
    drive(1'b1, 1'b1, 1'b0, 8'sd10, 8'sd10); tick(); chk("rst_en", acc32, 0);
    drive(1'b0, 1'b1, 1'b0, 8'sd2, 8'sd3);   tick(); chk("post_rst", acc32, 6);
    chk("post_rst_ovf", {31'd0, ovfs}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
